audio_frame_sequencer: RTL and testbench

// Host-side sequencer that drives the AudioProcessor frame interface. It streams NUM_FRAMES frames of

---
 rtl/audio_frame_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_audio_frame_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_frame_sequencer.sv
// Host-side sequencer: loads frames from storage into the AudioProcessor,
// pulses start, waits for a rising done, then drains results to the reader.
module audio_frame_sequencer #(
    parameter int unsigned WORDS_PER_FRAME = 64,
    parameter int unsigned DATA_W          = 512,
    parameter int unsigned NUM_FRAMES      = 4,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES  = 200000,
    localparam int unsigned IDX_W          = $clog2(WORDS_PER_FRAME)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    output logic              busy,
    output logic              run_done,
    output logic              err,
    output logic [15:0]       frame_cnt,
    output logic [ADDR_W-1:0] stor_index,
    input  logic [DATA_W-1:0] stor_data,
    output logic              proc_data_wr_en,
    output logic [IDX_W-1:0]  proc_input_index,
    output logic [DATA_W-1:0] proc_data_in,
    output logic              proc_start,
    input  logic              proc_done,
    output logic [IDX_W-1:0]  proc_output_index,
    input  logic [DATA_W-1:0] proc_data_out,
    output logic              rdr_wr_en,
    output logic [ADDR_W-1:0] rdr_index,
    output logic [DATA_W-1:0] rdr_data
);

    localparam int unsigned FRAME_W = 16;
    localparam int unsigned WAIT_W  = 32;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT, S_DRAIN, S_FIN, S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    word_q, word_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                done_q;
    logic                done_rise;
    logic                err_q, err_d;
    logic [FRAME_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic                busy_q, busy_d;
    logic                run_done_q, run_done_d;
    logic                wr_en_q, wr_en_d;
    logic [IDX_W-1:0]    in_idx_q, in_idx_d;
    logic [ADDR_W-1:0]   stor_idx_q, stor_idx_d;
    logic                start_q, start_d;
    logic                rdr_en_q, rdr_en_d;
    logic [IDX_W-1:0]    out_idx_q, out_idx_d;
    logic [ADDR_W-1:0]   rdr_idx_q, rdr_idx_d;
    logic [ADDR_W-1:0]   addr_d;
    logic                last_word;

    // Next-state, counters and next-cycle output values (outputs follow state_d)
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        frame_d     = frame_q;
        wait_d      = wait_q;
        err_d       = err_q;
        frame_cnt_d = frame_cnt_q;
        done_rise   = proc_done & ~done_q;
        last_word   = (word_q == IDX_W'(WORDS_PER_FRAME - 1));

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d     = S_LOAD;
                    err_d       = 1'b0;
                    frame_cnt_d = '0;
                    word_d      = '0;
                    frame_d     = '0;
                end
            end
            S_LOAD: begin
                if (last_word) state_d = S_START;
                else           word_d  = word_q + IDX_W'(1);
            end
            S_START: begin
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Only a fresh rising edge of done counts; a stale level is ignored
                if (done_rise) begin
                    state_d = S_DRAIN;
                    word_d  = '0;
                end else if ((TIMEOUT_CYCLES != 0) &&
                             (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1))) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DRAIN: begin
                if (last_word) begin
                    frame_cnt_d = frame_cnt_q + FRAME_W'(1);
                    if (frame_q == FRAME_W'(NUM_FRAMES - 1)) begin
                        state_d = S_FIN;
                    end else begin
                        frame_d = frame_q + FRAME_W'(1);
                        word_d  = '0;
                        state_d = S_LOAD;
                    end
                end else begin
                    word_d = word_q + IDX_W'(1);
                end
            end
            S_FIN:   state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_ERR) err_d = 1'b1;

        addr_d     = ADDR_W'(frame_d) * ADDR_W'(WORDS_PER_FRAME) + ADDR_W'(word_d);
        busy_d     = (state_d != S_IDLE);
        run_done_d = (state_d == S_FIN);
        wr_en_d    = (state_d == S_LOAD);
        start_d    = (state_d == S_START);
        rdr_en_d   = (state_d == S_DRAIN);
        in_idx_d   = wr_en_d  ? word_d : '0;
        out_idx_d  = rdr_en_d ? word_d : '0;
        stor_idx_d = wr_en_d  ? addr_d : '0;
        rdr_idx_d  = rdr_en_d ? addr_d : '0;
    end

    // State and registered outputs, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            word_q      <= '0;
            frame_q     <= '0;
            wait_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
            busy_q      <= 1'b0;
            run_done_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            in_idx_q    <= '0;
            stor_idx_q  <= '0;
            start_q     <= 1'b0;
            rdr_en_q    <= 1'b0;
            out_idx_q   <= '0;
            rdr_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            frame_q     <= frame_d;
            wait_q      <= wait_d;
            done_q      <= proc_done;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
            busy_q      <= busy_d;
            run_done_q  <= run_done_d;
            wr_en_q     <= wr_en_d;
            in_idx_q    <= in_idx_d;
            stor_idx_q  <= stor_idx_d;
            start_q     <= start_d;
            rdr_en_q    <= rdr_en_d;
            out_idx_q   <= out_idx_d;
            rdr_idx_q   <= rdr_idx_d;
        end
    end

    assign busy              = busy_q;
    assign run_done          = run_done_q;
    assign err               = err_q;
    assign frame_cnt         = frame_cnt_q;
    assign stor_index        = stor_idx_q;
    assign proc_data_wr_en   = wr_en_q;
    assign proc_input_index  = in_idx_q;
    assign proc_data_in      = stor_data;
    assign proc_start        = start_q;
    assign proc_output_index = out_idx_q;
    assign rdr_wr_en         = rdr_en_q;
    assign rdr_index         = rdr_idx_q;
    assign rdr_data          = proc_data_out;

endmodule

// File: tb/tb_audio_frame_sequencer.sv
// Self-checking bench for audio_frame_sequencer: identity processor model,
// storage/reader arrays and a done generator with configurable latency.
module tb_audio_frame_sequencer;

    localparam int WPF = 64;
    localparam int NF  = 4;
    localparam int TOT = WPF * NF;

    logic         clk = 1'b0;
    logic         rst, go, proc_done;
    logic         busy, run_done, err, proc_data_wr_en, proc_start, rdr_wr_en;
    logic [15:0]  frame_cnt;
    logic [31:0]  stor_index, rdr_index;
    logic [5:0]   proc_input_index, proc_output_index;
    logic [511:0] stor_data, proc_data_in, proc_data_out, rdr_data;

    // Second instance with a short timeout and a processor that never finishes
    logic         rst_t, go_t;
    logic         busy_t, run_done_t, err_t, wr_en_t, start_t, rdr_en_t;
    logic [15:0]  frame_cnt_t;
    logic [31:0]  stor_index_t, rdr_index_t;
    logic [5:0]   in_idx_t, out_idx_t;
    logic [511:0] pdin_t, rdr_data_t;
    logic [511:0] zero_w = '0;
    logic         done_t = 1'b0;

    logic [511:0] stor_mem [0:TOT-1];
    logic [511:0] pmem     [0:WPF-1];
    logic [511:0] rbuf     [0:TOT-1];

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    int wi_q[$], wa_q[$], ra_q[$], drain_q[$], start_q[$], rise_q[$];
    int n_rdone, n_excl, first_wr, n_rdr_t, n_rd_t, start_t_cyc;
    bit prev_rdr;
    int lat_fixed = 0;
    bit pre_high = 0, hold_first = 0;
    int go_cyc;

    audio_frame_sequencer dut (
        .clk(clk), .rst(rst), .go(go), .busy(busy), .run_done(run_done), .err(err),
        .frame_cnt(frame_cnt), .stor_index(stor_index), .stor_data(stor_data),
        .proc_data_wr_en(proc_data_wr_en), .proc_input_index(proc_input_index),
        .proc_data_in(proc_data_in), .proc_start(proc_start), .proc_done(proc_done),
        .proc_output_index(proc_output_index), .proc_data_out(proc_data_out),
        .rdr_wr_en(rdr_wr_en), .rdr_index(rdr_index), .rdr_data(rdr_data)
    );

    audio_frame_sequencer #(.TIMEOUT_CYCLES(50)) dut_to (
        .clk(clk), .rst(rst_t), .go(go_t), .busy(busy_t), .run_done(run_done_t), .err(err_t),
        .frame_cnt(frame_cnt_t), .stor_index(stor_index_t), .stor_data(zero_w),
        .proc_data_wr_en(wr_en_t), .proc_input_index(in_idx_t),
        .proc_data_in(pdin_t), .proc_start(start_t), .proc_done(done_t),
        .proc_output_index(out_idx_t), .proc_data_out(zero_w),
        .rdr_wr_en(rdr_en_t), .rdr_index(rdr_index_t), .rdr_data(rdr_data_t)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign stor_data     = (stor_index < 32'(TOT)) ? stor_mem[stor_index[7:0]] : '0;
    assign proc_data_out = pmem[proc_output_index];

    // Observe both DUTs mid-cycle; the processor model captures writes here
    always @(negedge clk) begin
        if (proc_data_wr_en === 1'b1) begin
            wi_q.push_back(int'(proc_input_index));
            wa_q.push_back(int'(stor_index));
            pmem[proc_input_index] = proc_data_in;
            if (first_wr < 0) first_wr = cyc;
        end
        if (proc_start === 1'b1) start_q.push_back(cyc);
        if (rdr_wr_en === 1'b1) begin
            ra_q.push_back(int'(rdr_index));
            if (rdr_index < 32'(TOT)) rbuf[rdr_index[7:0]] = rdr_data;
            if (!prev_rdr) drain_q.push_back(cyc);
        end
        prev_rdr = (rdr_wr_en === 1'b1);
        if (run_done === 1'b1) n_rdone++;
        if ((proc_data_wr_en === 1'b1) + (proc_start === 1'b1) + (rdr_wr_en === 1'b1) > 1) n_excl++;
        if (rdr_en_t === 1'b1) n_rdr_t++;
        if (run_done_t === 1'b1) n_rd_t++;
        if (start_t === 1'b1) start_t_cyc = cyc;
    end

    // Done generator: rises lat cycles after the start pulse, holds 3 cycles
    initial begin
        int lat;
        proc_done = 1'b0;
        forever begin
            @(negedge clk);
            if (pre_high) begin
                proc_done  = 1'b1;
                pre_high   = 0;
                hold_first = 1;
            end else if (proc_start === 1'b1) begin
                if (hold_first) begin
                    hold_first = 0;
                    repeat (30) @(negedge clk);
                    proc_done = 1'b0;
                    repeat (2) @(negedge clk);
                end else begin
                    lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(40, 1));
                    repeat (lat) @(negedge clk);
                end
                proc_done = 1'b1;
                rise_q.push_back(cyc);
                repeat (3) @(negedge clk);
                proc_done = 1'b0;
            end
        end
    end

    task automatic clear_mon();
        wi_q.delete(); wa_q.delete(); ra_q.delete();
        drain_q.delete(); start_q.delete(); rise_q.delete();
        n_rdone = 0; first_wr = -1;
        for (int i = 0; i < TOT; i++) rbuf[i] = '0;
    endtask

    // Pulse go and wait for run_done; mode 1 also pulses go during LOAD and WAIT
    task automatic do_run(input int mode, output bit finished);
        int n;
        clear_mon();
        @(negedge clk);
        go = 1'b1; go_cyc = cyc;
        n = 0; finished = 0;
        while (n < 4000 && !finished) begin
            @(negedge clk);
            n++;
            go = (mode == 1) && (n == 10 || n == 68);
            if (n_rdone > 0) finished = 1;
        end
        go = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; go = 1'b0; rst_t = 1'b1; go_t = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, run_done, err, proc_data_wr_en, proc_start, rdr_wr_en} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b required 000000",
                     {busy, run_done, err, proc_data_wr_en, proc_start, rdr_wr_en});
        end
        checks++;
        if (frame_cnt !== 16'd0 || stor_index !== 32'd0 || rdr_index !== 32'd0 ||
            proc_input_index !== 6'd0 || proc_output_index !== 6'd0) begin
            failures++;
            $display("FAIL reset_counts: frame_cnt=%0d stor=%0d rdr=%0d in=%0d out=%0d required all 0",
                     frame_cnt, stor_index, rdr_index, proc_input_index, proc_output_index);
        end
        checks++;
        if (busy_t !== 1'b0 || err_t !== 1'b0) begin
            failures++;
            $display("FAIL reset_to_inst: busy=%b err=%b required 0 0", busy_t, err_t);
        end
        rst = 1'b0; rst_t = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_run();
        bit fin;
        int bad;
        lat_fixed = 100;
        do_run(0, fin);
        checks++;
        if (!fin) begin
            failures++;
            $display("FAIL basic_finish: run_done not seen within bound, required within 4000 cycles");
        end
        checks++;
        if (first_wr != go_cyc + 1) begin
            failures++;
            $display("FAIL basic_first_load: first wr cycle %0d required %0d", first_wr, go_cyc + 1);
        end
        bad = 0;
        foreach (wi_q[i]) if (wi_q[i] != i % WPF || wa_q[i] != i) bad++;
        checks++;
        if (wi_q.size() != TOT || bad != 0) begin
            failures++;
            $display("FAIL basic_load_seq: writes=%0d bad=%0d required writes=%0d bad=0",
                     wi_q.size(), bad, TOT);
        end
        bad = 0;
        foreach (ra_q[i]) if (ra_q[i] != i) bad++;
        checks++;
        if (ra_q.size() != TOT || bad != 0) begin
            failures++;
            $display("FAIL basic_drain_seq: writes=%0d bad=%0d required writes=%0d bad=0",
                     ra_q.size(), bad, TOT);
        end
        checks++;
        if (start_q.size() != NF || n_rdone != 1 || frame_cnt !== 16'(NF) || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_totals: starts=%0d run_done=%0d frame_cnt=%0d busy=%b required %0d 1 %0d 0",
                     start_q.size(), n_rdone, frame_cnt, busy, NF, NF);
        end
        bad = 0;
        for (int k = 0; k < NF && k < start_q.size() && k < drain_q.size(); k++)
            if (drain_q[k] - start_q[k] != 101) bad++;
        checks++;
        if (bad != 0 || drain_q.size() != NF) begin
            failures++;
            $display("FAIL basic_done_latency: bad=%0d drains=%0d required bad=0 drains=%0d",
                     bad, drain_q.size(), NF);
        end
    endtask

    task automatic test_identity_data();
        bit fin;
        int bad;
        lat_fixed = 0;
        for (int i = 0; i < TOT; i++)
            for (int k = 0; k < 16; k++) stor_mem[i][k*32 +: 32] = $urandom();
        do_run(0, fin);
        bad = 0;
        for (int i = 0; i < TOT; i++) if (rbuf[i] !== stor_mem[i]) bad++;
        checks++;
        if (!fin || bad != 0) begin
            failures++;
            $display("FAIL identity_data: finished=%0d bad_words=%0d required finished=1 bad_words=0", fin, bad);
        end
        bad = 0;
        for (int k = 0; k < rise_q.size() && k < drain_q.size(); k++)
            if (drain_q[k] != rise_q[k] + 1) bad++;
        checks++;
        if (bad != 0 || rise_q.size() != NF || drain_q.size() != NF) begin
            failures++;
            $display("FAIL identity_rise_to_drain: bad=%0d rises=%0d drains=%0d required 0 %0d %0d",
                     bad, rise_q.size(), drain_q.size(), NF, NF);
        end
    endtask

    task automatic test_done_held();
        bit fin;
        lat_fixed = 5;
        pre_high = 1;
        do_run(0, fin);
        checks++;
        if (!fin || start_q.size() < 1 || drain_q.size() < 1 || rise_q.size() < 1 ||
            drain_q[0] - start_q[0] != 33 || drain_q[0] != rise_q[0] + 1) begin
            failures++;
            $display("FAIL done_held: finished=%0d start=%0d drain=%0d rise=%0d required drain=start+33=rise+1",
                     fin, (start_q.size() > 0) ? start_q[0] : -1,
                     (drain_q.size() > 0) ? drain_q[0] : -1, (rise_q.size() > 0) ? rise_q[0] : -1);
        end
    endtask

    task automatic test_timeout();
        int n, g, e;
        n_rdr_t = 0; n_rd_t = 0;
        @(negedge clk);
        go_t = 1'b1; g = cyc;
        @(negedge clk);
        go_t = 1'b0;
        n = 0; e = -1;
        while (n < 500 && e < 0) begin
            if (err_t === 1'b1) e = cyc;
            else begin @(negedge clk); n++; end
        end
        checks++;
        if (e != g + 116 || e - start_t_cyc != 51) begin
            failures++;
            $display("FAIL timeout_cycle: err at %0d (start %0d) required %0d (start+51)",
                     e, start_t_cyc, g + 116);
        end
        @(negedge clk);
        checks++;
        if (busy_t !== 1'b0 || err_t !== 1'b1 || n_rdr_t != 0 || n_rd_t != 0) begin
            failures++;
            $display("FAIL timeout_after: busy=%b err=%b rdr_writes=%0d run_done=%0d required 0 1 0 0",
                     busy_t, err_t, n_rdr_t, n_rd_t);
        end
        go_t = 1'b1;
        @(negedge clk);
        go_t = 1'b0;
        checks++;
        if (err_t !== 1'b0 || busy_t !== 1'b1) begin
            failures++;
            $display("FAIL timeout_go_clears: err=%b busy=%b required 0 1", err_t, busy_t);
        end
    endtask

    task automatic test_go_ignored();
        bit fin;
        int bad;
        lat_fixed = 20;
        do_run(1, fin);
        bad = 0;
        foreach (wa_q[i]) if (wa_q[i] != i) bad++;
        foreach (ra_q[i]) if (ra_q[i] != i) bad++;
        checks++;
        if (!fin || bad != 0 || wa_q.size() != TOT || ra_q.size() != TOT ||
            frame_cnt !== 16'(NF) || n_rdone != 1 || start_q.size() != NF) begin
            failures++;
            $display("FAIL go_ignored: fin=%0d bad=%0d loads=%0d drains=%0d frame_cnt=%0d run_done=%0d starts=%0d required 1 0 %0d %0d %0d 1 %0d",
                     fin, bad, wa_q.size(), ra_q.size(), frame_cnt, n_rdone, start_q.size(), TOT, TOT, NF, NF);
        end
    endtask

    task automatic test_reset_mid_drain();
        bit fin;
        int n;
        lat_fixed = 10;
        clear_mon();
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        n = 0;
        while (n < 2000 && ra_q.size() < 2 * WPF + 10) begin @(negedge clk); n++; end
        checks++;
        if (ra_q.size() < 2 * WPF + 10) begin
            failures++;
            $display("FAIL rst_mid_reach: drain writes=%0d required %0d", ra_q.size(), 2 * WPF + 10);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({proc_data_wr_en, proc_start, rdr_wr_en, busy, run_done} !== 5'b0 ||
            frame_cnt !== 16'd0 || rdr_index !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid_outputs: strobes/busy/done=%b frame_cnt=%0d rdr_index=%0d required 00000 0 0",
                     {proc_data_wr_en, proc_start, rdr_wr_en, busy, run_done}, frame_cnt, rdr_index);
        end
        repeat (20) @(negedge clk);
        do_run(0, fin);
        checks++;
        if (!fin || wa_q.size() != TOT || wa_q[0] != 0 || first_wr != go_cyc + 1 || frame_cnt !== 16'(NF)) begin
            failures++;
            $display("FAIL rst_mid_restart: fin=%0d loads=%0d first_addr=%0d first_cyc=%0d frame_cnt=%0d required 1 %0d 0 %0d %0d",
                     fin, wa_q.size(), (wa_q.size() > 0) ? wa_q[0] : -1, first_wr, frame_cnt, TOT, go_cyc + 1, NF);
        end
    endtask

    initial begin
        for (int i = 0; i < TOT; i++) stor_mem[i] = {16{32'(i)}};
        for (int i = 0; i < WPF; i++) pmem[i] = '0;
        n_excl = 0; prev_rdr = 0; start_t_cyc = -1;
        clear_mon();
        test_reset();
        n_excl = 0;
        test_basic_run();
        test_identity_data();
        test_done_held();
        test_timeout();
        test_go_ignored();
        test_reset_mid_drain();
        checks++;
        if (n_excl != 0) begin
            failures++;
            $display("FAIL strobe_exclusive: overlapping strobe cycles=%0d required 0", n_excl);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
